// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Optional build macro: VECTORED_MODE_EN (vectored interrupt targets).
package trap_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_JUMP,
    ST_RETURN
  } state_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_e;

  localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

  function automatic logic [31:0] trap_base(
    input logic [31:0] mtvec
  );
    return mtvec & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/trap_controller_sync_chain.sv
// Multi-flop synchroniser for one asynchronous level input.
// Reset clears every stage so no stale request survives reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: exception/interrupt entry and MRET return.
// Optional build macro: VECTORED_MODE_EN (vectored interrupt targets).
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception,
  input  logic [3:0]  excCause,
  input  logic [31:0] excPc,
  input  logic [31:0] curPc,
  input  logic        mret,
  input  logic        irqExt,
  input  logic        irqTimer,
  input  logic [31:0] mtvecDo,
  input  logic [31:0] mepcDo,
  output logic        mepcWe,
  output logic        mcauseWe,
  output logic [31:0] mepcDi,
  output logic [31:0] mcauseDi,
  output logic        pcRedirect,
  output logic [31:0] pcTarget,
  output logic        stall
);

  state_e      state_q, state_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] cause_q, cause_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        ext_s, tmr_s;
  logic [31:0] jump_target;

  sync_chain #(.STAGES(IRQ_SYNC_STAGES)) u_sync_ext (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (irqExt),
    .q_o    (ext_s)
  );

  sync_chain #(.STAGES(IRQ_SYNC_STAGES)) u_sync_tmr (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (irqTimer),
    .q_o    (tmr_s)
  );

`ifdef VECTORED_MODE_EN
  // Only interrupts vector; exceptions always land on the base.
  assign jump_target =
    (cause_q[31] && mtvecDo[1:0] == MTVEC_VECTORED) ?
    trap_base(mtvecDo) + {26'b0, cause_q[3:0], 2'b00} :
    trap_base(mtvecDo);
`else
  assign jump_target = trap_base(mtvecDo);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mepc_q  <= '0;
      cause_q <= '0;
      mie_q   <= 1'b1;
      mpie_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mepc_q  <= mepc_d;
      cause_q <= cause_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mepc_d     = mepc_q;
    cause_d    = cause_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mepcWe     = 1'b0;
    mcauseWe   = 1'b0;
    mepcDi     = '0;
    mcauseDi   = '0;
    pcRedirect = 1'b0;
    pcTarget   = '0;
    stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        priority case (1'b1)
          exception: begin
            mepc_d  = excPc;
            cause_d = {28'b0, excCause};
            state_d = ST_SAVE;
            stall   = 1'b1;
          end
          (ext_s && mie_q): begin
            mepc_d  = curPc;
            cause_d = CAUSE_IRQ_EXT;
            state_d = ST_SAVE;
            stall   = 1'b1;
          end
          (tmr_s && mie_q): begin
            mepc_d  = curPc;
            cause_d = CAUSE_IRQ_TIMER;
            state_d = ST_SAVE;
            stall   = 1'b1;
          end
          mret: begin
            state_d = ST_RETURN;
            stall   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_SAVE: begin
        mepcWe   = 1'b1;
        mcauseWe = 1'b1;
        mepcDi   = mepc_q;
        mcauseDi = cause_q;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        state_d  = ST_JUMP;
        stall    = 1'b1;
      end
      ST_JUMP: begin
        pcRedirect = 1'b1;
        pcTarget   = jump_target;
        state_d    = ST_IDLE;
        stall      = 1'b1;
      end
      ST_RETURN: begin
        pcRedirect = 1'b1;
        pcTarget   = mepcDo;
        mie_d      = mpie_q;
        mpie_d     = 1'b1;
        state_d    = ST_IDLE;
        stall      = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Randomised scoreboard bench for trap_controller.
// Honours VECTORED_MODE_EN in its reference model.
module tb_trap_controller;

  localparam int S = 2;
  localparam logic [31:0] C_EXT = 32'h8000_000B;
  localparam logic [31:0] C_TMR = 32'h8000_0007;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exception = 1'b0;
  logic [3:0]  excCause = '0;
  logic [31:0] excPc = '0;
  logic [31:0] curPc = '0;
  logic        mret = 1'b0;
  logic        irqExt = 1'b0;
  logic        irqTimer = 1'b0;
  logic [31:0] mtvecDo = '0;
  logic [31:0] mepcDo = '0;
  logic        mepcWe, mcauseWe, pcRedirect, stall;
  logic [31:0] mepcDi, mcauseDi, pcTarget;

  trap_controller #(.IRQ_SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .exception  (exception),
    .excCause   (excCause),
    .excPc      (excPc),
    .curPc      (curPc),
    .mret       (mret),
    .irqExt     (irqExt),
    .irqTimer   (irqTimer),
    .mtvecDo    (mtvecDo),
    .mepcDo     (mepcDo),
    .mepcWe     (mepcWe),
    .mcauseWe   (mcauseWe),
    .mepcDi     (mepcDi),
    .mcauseDi   (mcauseDi),
    .pcRedirect (pcRedirect),
    .pcTarget   (pcTarget),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          red;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  m_mie = 1'b1;
  bit  m_mpie = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] tgt(
    input logic [31:0] mt,
    input logic [31:0] cause
  );
    logic [31:0] base;
    base = mt - (mt % 4);
`ifdef VECTORED_MODE_EN
    if (cause >= 32'h8000_0000 && (mt % 4) == 1)
      return base + (cause % 16) * 4;
`endif
    return base;
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_trap(
    input logic [31:0] pc,
    input logic [31:0] cause,
    input int          c
  );
    sb.push_back(ev_t'{1'b0, pc, cause, c});
    sb.push_back(ev_t'{1'b1, tgt(mtvecDo, cause), 32'h0, c + 1});
  endtask

  always @(negedge clk) begin
    #4;
    if (mepcWe || mcauseWe) begin
      checks++;
      if (sb.size() == 0 || sb[0].red) begin
        errors++;
        $display("FAIL csr_write: unexpected mepc=%h mcause=%h cyc=%0d",
                 mepcDi, mcauseDi, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (!(mepcWe && mcauseWe) || mepcDi !== mon_e.a ||
            mcauseDi !== mon_e.b || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL csr_write: got we=%b%b mepc=%h mcause=%h cyc=%0d expected mepc=%h mcause=%h cyc=%0d",
                   mepcWe, mcauseWe, mepcDi, mcauseDi, cyc,
                   mon_e.a, mon_e.b, mon_e.cyc);
        end
      end
    end
    if (pcRedirect) begin
      checks++;
      if (sb.size() == 0 || !sb[0].red) begin
        errors++;
        $display("FAIL redirect: unexpected target=%h cyc=%0d",
                 pcTarget, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (pcTarget !== mon_e.a || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL redirect: got target=%h cyc=%0d expected target=%h cyc=%0d",
                   pcTarget, cyc, mon_e.a, mon_e.cyc);
        end
      end
    end
  end

  task automatic idle_chk(input string tag);
    chk({tag, "_ctl"}, {28'b0, mepcWe, mcauseWe, pcRedirect, stall}, 32'h0);
    chk({tag, "_data"}, mepcDi | mcauseDi | pcTarget, 32'h0);
  endtask

  // Each op starts and ends at a falling edge.
  task automatic settle(input bit lower);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    if (lower) begin
      irqExt = 1'b0;
      irqTimer = 1'b0;
    end
    repeat (6) @(negedge clk);
    #4 idle_chk("idle");
    @(negedge clk);
  endtask

  task automatic op_exc(
    input logic [3:0]  c,
    input logic [31:0] pc,
    input bit          with_irq
  );
    int hold;
    hold = $urandom_range(1, 3);
    exception = 1'b1;
    excCause = c;
    excPc = pc;
    if (with_irq) irqExt = 1'b1;
    push_trap(pc, {28'b0, c}, cyc + 1);
    m_mpie = m_mie;
    m_mie = 1'b0;
    #4 chk("exc_accept_stall", {31'b0, stall}, 32'h1);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      excPc = $urandom;
      excCause = 4'($urandom);
    end
    @(negedge clk);
    exception = 1'b0;
  endtask

  task automatic op_mret(input logic [31:0] epc);
    int  hold;
    bit  nm;
    hold = $urandom_range(1, 2);
    mret = 1'b1;
    mepcDo = epc;
    sb.push_back(ev_t'{1'b1, epc, 32'h0, cyc + 1});
    nm = m_mpie;
    m_mpie = 1'b1;
    m_mie = nm;
    if (m_mie && (irqExt || irqTimer)) begin
      push_trap(curPc, irqExt ? C_EXT : C_TMR, cyc + 3);
      m_mpie = 1'b1;
      m_mie = 1'b0;
    end
    #4 chk("mret_accept_stall", {31'b0, stall}, 32'h1);
    if (hold == 2) @(negedge clk);
    @(negedge clk);
    mret = 1'b0;
  endtask

  task automatic op_irq(
    input bit          ext,
    input bit          tmr,
    input logic [31:0] pc
  );
    curPc = pc;
    irqExt = ext;
    irqTimer = tmr;
    if (m_mie) begin
      push_trap(pc, ext ? C_EXT : C_TMR, cyc + S + 1);
      m_mpie = 1'b1;
      m_mie = 1'b0;
    end
    repeat (S + 6) @(negedge clk);
  endtask

  task automatic op_reset(input int phase);
    exception = 1'b1;
    excCause = 4'($urandom);
    excPc = $urandom;
    if (phase == 2)
      sb.push_back(ev_t'{1'b0, excPc, {28'b0, excCause}, cyc + 1});
    @(negedge clk);
    exception = 1'b0;
    if (phase == 2) @(negedge clk);
    rst_n = 1'b0;
    m_mie = 1'b1;
    m_mpie = 1'b0;
    #4 idle_chk("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    settle(1'b1);
  endtask

  initial begin
    int op;
    repeat (3) @(negedge clk);
    #4 idle_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mtvecDo = 32'h200;
    op_exc(4'd2, 32'h100, 1'b0);
    settle(1'b1);
    op_irq(1'b0, 1'b1, 32'h40);
    settle(1'b1);
    op_mret(32'h84);
    settle(1'b1);
    curPc = 32'h0000_0abc;
    op_exc(4'd5, 32'h300, 1'b1);
    settle(1'b0);
    op_mret(32'h304);
    settle(1'b1);
    op_reset(1);
    mtvecDo = 32'h201;
    op_irq(1'b1, 1'b0, 32'h500);
    settle(1'b1);
    for (int it = 0; it < 60; it++) begin
      mtvecDo = $urandom;
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          op_exc(4'($urandom), $urandom, 1'b0);
          settle(1'b1);
        end
        1: begin
          case ($urandom_range(0, 2))
            0: op_irq(1'b1, 1'b0, $urandom);
            1: op_irq(1'b0, 1'b1, $urandom);
            default: op_irq(1'b1, 1'b1, $urandom);
          endcase
          settle(1'b1);
        end
        2: begin
          op_mret($urandom);
          settle(1'b1);
        end
        3: begin
          curPc = $urandom;
          op_exc(4'($urandom), $urandom, 1'b1);
          settle(1'b0);
          op_mret($urandom);
          settle(1'b1);
        end
        default: op_reset($urandom_range(1, 2));
      endcase
    end
    chk("final_queue", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
